// File: rtl/axis_fifo_if.sv
// AXI4-Stream beat bundle shared by the FIFO's slave and master sides.
interface axis_fifo_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic                       tlast;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TUSER_WIDTH-1:0]     tuser;

    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_fifo.sv
// AXI4-Stream FIFO: DEPTH-1 entry memory plus a registered output stage,
// with optional store-and-forward gating on TLAST.
module axis_fifo #(
    parameter int DEPTH       = 16,
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int PACKET_MODE = 0
) (
    input  logic                     aclk,
    input  logic                     areset,
    axis_fifo_if.slave               s,
    axis_fifo_if.master              m,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [$clog2(DEPTH):0]   pkt_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int ME = DEPTH - 1;
    localparam int AW = (ME > 1) ? $clog2(ME) : 1;
    localparam int KW = TDATA_WIDTH / 8;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic [KW-1:0]          keep;
        logic [KW-1:0]          strb;
        logic                   last;
        logic [TID_WIDTH-1:0]   id;
        logic [TDEST_WIDTH-1:0] dest;
        logic [TUSER_WIDTH-1:0] user;
    } beat_t;

    beat_t           mem [0:ME-1];
    beat_t           in_beat, out_q;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            out_full, vld, rdy, cut;
    logic            acc, xfer, mem_empty, load, out_full_n, cut_n, vld_n;
    logic [CW-1:0]   fill_n, pkt_old, pkt_n;

    // Index wraps at ME (not a power of two), toggling the wrap bit.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(ME - 1))
            return {~p[AW], {AW{1'b0}}};
        return {p[AW], p[AW-1:0] + AW'(1)};
    endfunction

    assign in_beat = {s.tdata, s.tkeep, s.tstrb, s.tlast, s.tid, s.tdest, s.tuser};

    always_comb begin
        acc        = s.tvalid && rdy;
        xfer       = vld && m.tready;
        mem_empty  = (wr_ptr == rd_ptr);
        load       = (!out_full || xfer) && !mem_empty;
        out_full_n = load || (out_full && !xfer);
        fill_n     = fill + CW'(acc) - CW'(xfer);
        pkt_old    = pkt_cnt - CW'(xfer && out_q.last);
        pkt_n      = pkt_old + CW'(acc && s.tlast);
        cut_n      = xfer ? !out_q.last : cut;
        // Head packet is complete iff any TLAST remains once the outgoing beat
        // leaves; the incoming TLAST only counts from the following edge.
        if (PACKET_MODE == 0)
            vld_n = out_full_n;
        else
            vld_n = out_full_n && ((vld && !xfer) || cut_n || (pkt_old != '0) ||
                                   (fill_n == CW'(DEPTH)));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_q    <= '0;
            out_full <= 1'b0;
            vld      <= 1'b0;
            rdy      <= 1'b0;
            cut      <= 1'b0;
            fill     <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (acc)  wr_ptr <= ptr_inc(wr_ptr);
            if (load) begin
                rd_ptr <= ptr_inc(rd_ptr);
                out_q  <= mem[rd_ptr[AW-1:0]];
            end
            out_full <= out_full_n;
            vld      <= vld_n;
            cut      <= cut_n;
            fill     <= fill_n;
            pkt_cnt  <= pkt_n;
            rdy      <= (fill_n < CW'(DEPTH));
        end
    end

    always_ff @(posedge aclk) begin
        if (acc) mem[wr_ptr[AW-1:0]] <= in_beat;
    end

    assign s.tready = rdy;
    assign m.tvalid = vld;
    assign m.tdata  = out_q.data;
    assign m.tkeep  = out_q.keep;
    assign m.tstrb  = out_q.strb;
    assign m.tlast  = out_q.last;
    assign m.tid    = out_q.id;
    assign m.tdest  = out_q.dest;
    assign m.tuser  = out_q.user;
endmodule

// File: tb/tb_axis_fifo.sv
// Directed and randomized checks of axis_fifo in stream and packet mode.
module tb_axis_fifo;
    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       st;
        logic       l;
        logic       id;
        logic       de;
        logic       u;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel, tv, mr;
    beat_t      tb_in, mbeat, hold_beat;
    logic       srdy, mvld, hold;
    logic [4:0] fill0, pkt0, fill1, pkt1, fill, pkt;

    axis_fifo_if s0(), m0(), s1(), m1();

    axis_fifo #(.DEPTH(16), .PACKET_MODE(0)) u0 (
        .aclk(clk), .areset(rst), .s(s0), .m(m0), .fill(fill0), .pkt_cnt(pkt0));
    axis_fifo #(.DEPTH(16), .PACKET_MODE(1)) u1 (
        .aclk(clk), .areset(rst), .s(s1), .m(m1), .fill(fill1), .pkt_cnt(pkt1));

    assign s0.tvalid = tv && !sel;
    assign s1.tvalid = tv && sel;
    assign {s0.tdata, s0.tkeep, s0.tstrb, s0.tlast, s0.tid, s0.tdest, s0.tuser} = tb_in;
    assign {s1.tdata, s1.tkeep, s1.tstrb, s1.tlast, s1.tid, s1.tdest, s1.tuser} = tb_in;
    assign m0.tready = mr && !sel;
    assign m1.tready = mr && sel;
    assign srdy  = sel ? s1.tready : s0.tready;
    assign mvld  = sel ? m1.tvalid : m0.tvalid;
    assign mbeat = sel ? {m1.tdata, m1.tkeep, m1.tstrb, m1.tlast, m1.tid, m1.tdest, m1.tuser}
                       : {m0.tdata, m0.tkeep, m0.tstrb, m0.tlast, m0.tid, m0.tdest, m0.tuser};
    assign fill  = sel ? fill1 : fill0;
    assign pkt   = sel ? pkt1 : pkt0;

    int    total = 0, bad = 0;
    beat_t got_q[$], exp_q[$];
    int    cyc = 0, nacc, first_acc, first_vld, first_xf, last_xf, vld_fill;
    int    acc_tot, xf_tot, lacc, lxf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int i, input logic l);
        beat_t b;
        b    = '0;
        b.d  = i[7:0];
        b.k  = 1'b1;
        b.st = 1'b1;
        b.l  = l;
        return b;
    endfunction

    task automatic clr();
        got_q.delete();
        exp_q.delete();
        nacc = 0; first_acc = -1; first_vld = -1; first_xf = -1; last_xf = -1;
        vld_fill = -1; hold = 1'b0; tv = 1'b0;
    endtask

    // One clock: observe handshakes at the falling edge, return 1ns after the rising edge.
    task automatic step();
        @(negedge clk);
        if (hold) chk("stable", 32'({mvld, mbeat}), 32'({1'b1, hold_beat}));
        if (tv && srdy) begin
            exp_q.push_back(tb_in);
            nacc++; acc_tot++;
            if (tb_in.l) lacc++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (mvld) begin
            if (first_vld < 0) begin first_vld = cyc; vld_fill = int'(fill); end
            if (mr) begin
                got_q.push_back(mbeat);
                xf_tot++;
                if (mbeat.l) lxf++;
                if (first_xf < 0) first_xf = cyc;
                last_xf = cyc;
            end
        end
        hold      = mvld && !mr;
        hold_beat = mbeat;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_run(input logic md, input int n, input int maxlen);
        int left, n0;
        clr();
        sel = md; acc_tot = 0; xf_tot = 0; lacc = 0; lxf = 0;
        left = $urandom_range(1, maxlen);
        for (int t = 0; t < 10 * n && got_q.size() < n; t++) begin
            if (!tv) begin
                tv       = (nacc < n) && ($urandom_range(0, 1) == 1);
                tb_in    = mk(nacc, (left == 1) || (nacc == n - 1));
                tb_in.k  = 1'($urandom);
                tb_in.st = 1'($urandom);
                tb_in.id = 1'($urandom);
                tb_in.de = 1'($urandom);
                tb_in.u  = 1'($urandom);
            end
            mr = 1'($urandom);
            n0 = nacc;
            step();
            if (nacc != n0) begin
                tv   = 1'b0;
                left = (left == 1) ? $urandom_range(1, maxlen) : left - 1;
            end
            chk("r_fill", 32'(fill), 32'(acc_tot - xf_tot));
            chk("r_pkt", 32'(pkt), 32'(lacc - lxf));
        end
        tv = 1'b0;
        chk("r_cnt", 32'(got_q.size()), 32'(n));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("r_beat", 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; tv = 1'b0; mr = 1'b0; tb_in = '0; hold = 1'b0;
        acc_tot = 0; xf_tot = 0; lacc = 0; lxf = 0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld0", 32'(m0.tvalid), 0);
        chk("rst_rdy0", 32'(s0.tready), 0);
        chk("rst_fill0", 32'(fill0), 0);
        chk("rst_pkt0", 32'(pkt0), 0);
        chk("rst_data0", 32'(mbeat), 0);
        chk("rst_vld1", 32'(m1.tvalid), 0);
        chk("rst_rdy1", 32'(s1.tready), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_rdy0", 32'(s0.tready), 1);
        chk("rel_rdy1", 32'(s1.tready), 1);

        // Mode 0 streaming: 40 beats, sink always ready.
        clr(); sel = 1'b0; mr = 1'b1;
        for (int t = 0; t < 200 && got_q.size() < 40; t++) begin
            tv = (nacc < 40); tb_in = mk(nacc, 1'b0);
            step();
        end
        tv = 1'b0;
        chk("a_cnt", 32'(got_q.size()), 40);
        for (int i = 0; i < got_q.size(); i++) chk("a_data", 32'(got_q[i].d), 32'(i));
        chk("a_lat", 32'(first_vld - first_acc), 2);
        chk("a_thru", 32'(last_xf - first_xf), 39);
        chk("a_fill", 32'(fill), 0);

        // Mode 0 fill: sink stalled while 20 beats are offered.
        clr(); sel = 1'b0; mr = 1'b0;
        for (int t = 0; t < 25; t++) begin
            tv = (nacc < 20); tb_in = mk(nacc, 1'b0);
            step();
        end
        chk("b_acc", 32'(nacc), 16);
        chk("b_fill", 32'(fill), 16);
        chk("b_rdy", 32'(srdy), 0);
        chk("b_vld", 32'(mvld), 1);
        mr = 1'b1;
        for (int t = 0; t < 100 && got_q.size() < 20; t++) begin
            tv = (nacc < 20); tb_in = mk(nacc, 1'b0);
            step();
        end
        tv = 1'b0;
        chk("b_cnt", 32'(got_q.size()), 20);
        for (int i = 0; i < got_q.size(); i++) chk("b_data", 32'(got_q[i].d), 32'(i));

        // Mode 1: 5-beat packet with a 3-cycle gap before TLAST.
        clr(); sel = 1'b1; mr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tv = 1'b1; tb_in = mk(i, 1'b0);
            step();
        end
        tv = 1'b0;
        chk("c_acc", 32'(nacc), 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("c_gap_vld", 32'(mvld), 0);
        end
        chk("c_pkt0", 32'(pkt), 0);
        tv = 1'b1; tb_in = mk(4, 1'b1);
        step();
        tv = 1'b0;
        chk("c_pkt1", 32'(pkt), 1);
        chk("c_vld_k", 32'(mvld), 0);
        step();
        chk("c_vld_k1", 32'(mvld), 1);
        for (int t = 0; t < 20 && got_q.size() < 5; t++) step();
        chk("c_cnt", 32'(got_q.size()), 5);
        for (int i = 0; i < got_q.size(); i++)
            chk("c_beat", 32'({got_q[i].d, got_q[i].l}), 32'({i[7:0], i == 4}));
        chk("c_pkt_end", 32'(pkt), 0);

        // Mode 1 oversize: 20-beat packet must cut through once full.
        clr(); sel = 1'b1; mr = 1'b1;
        for (int t = 0; t < 200 && got_q.size() < 20; t++) begin
            tv = (nacc < 20); tb_in = mk(nacc, nacc == 19);
            step();
        end
        tv = 1'b0;
        chk("d_fill", 32'(vld_fill), 16);
        chk("d_cnt", 32'(got_q.size()), 20);
        for (int i = 0; i < got_q.size(); i++)
            chk("d_beat", 32'({got_q[i].d, got_q[i].l}), 32'({i[7:0], i == 19}));
        chk("d_pkt", 32'(pkt), 0);

        rand_run(1'b0, 1000, 4);
        rand_run(1'b1, 300, 6);

        // Reset with 7 beats and 2 complete packets held.
        clr(); sel = 1'b1; mr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tv = 1'b1; tb_in = mk(i, (i == 2) || (i == 5));
            step();
        end
        tv = 1'b0;
        chk("g_fill", 32'(fill), 7);
        chk("g_pkt", 32'(pkt), 2);
        #2 rst = 1'b1;
        #1;
        chk("g_rst_vld", 32'(mvld), 0);
        chk("g_rst_rdy", 32'(srdy), 0);
        chk("g_rst_fill", 32'(fill), 0);
        chk("g_rst_pkt", 32'(pkt), 0);
        chk("g_rst_data", 32'(mbeat), 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("g_rel_rdy", 32'(srdy), 1);
        clr(); mr = 1'b1;
        repeat (4) step();
        chk("g_stale", 32'(got_q.size()), 0);
        chk("g_stale_vld", 32'(mvld), 0);
        tv = 1'b1; tb_in = mk(8'hA5, 1'b1);
        step();
        tv = 1'b0;
        for (int t = 0; t < 10 && got_q.size() < 1; t++) step();
        chk("g_cnt", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk("g_data", 32'({got_q[0].d, got_q[0].l}), 32'({8'hA5, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
